cf_uart_wb_seq: RTL and testbench

Wishbone master sequencer that owns the `CF_UART_WB` slave port. After reset it programs the prescaler, line configuration and control registers. It then round-robin arbitrates two byte-stream transmit requesters onto TXDATA and drains received bytes from RXDATA onto a byte-stream output. It sits between on-chip byte producers/consumers and the UART, replacing software register polling.

---
 rtl/cf_uart_wb_seq.sv | 240 ++++++++++++++++++++++++
 tb/tb_cf_uart_wb_seq.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cf_uart_wb_seq.sv
// cf_uart_wb_seq: Wishbone master that initialises the CF_UART_WB slave, then
// moves bytes between two TX requesters / one RX stream and the UART FIFOs.
// Ports: clk_i, rst_i (async, active-high); wbm_* classic Wishbone master;
//   a_*/b_* TX byte streams (valid/ready); rx_* RX byte stream; init_done.
// Option: define CF_UART_SEQ_RX_EN to build the RXDATA drain path.
module cf_uart_wb_seq #(
  parameter int          AW           = 16,
  parameter logic [15:0] PR_INIT      = 16'd10,
  parameter logic [31:0] CFG_INIT     = 32'h0000_3F08,
  parameter logic [31:0] CTRL_INIT    = 32'h0000_0007,
  parameter int          TX_READY_BIT = 0,
  parameter int          RX_AVAIL_BIT = 3,
  parameter int          POLL_GAP     = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic [AW-1:0] wbm_adr_o,
  output logic [31:0]   wbm_dat_o,
  input  logic [31:0]   wbm_dat_i,
  output logic [3:0]    wbm_sel_o,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic          wbm_we_o,
  input  logic          wbm_ack_i,
  input  logic [7:0]    a_data,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [7:0]    b_data,
  input  logic          b_valid,
  output logic          b_ready,
  output logic [7:0]    rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic          init_done
);

  localparam logic [AW-1:0] ADR_RX   = AW'(16'h0000);
  localparam logic [AW-1:0] ADR_TX   = AW'(16'h0004);
  localparam logic [AW-1:0] ADR_PR   = AW'(16'h0008);
  localparam logic [AW-1:0] ADR_CTRL = AW'(16'h000C);
  localparam logic [AW-1:0] ADR_CFG  = AW'(16'h0010);
  localparam logic [AW-1:0] ADR_RIS  = AW'(16'h0F08);

  typedef enum logic [2:0] {
    S_INIT_PR,
    S_INIT_CFG,
    S_INIT_CTRL,
    S_POLL,
    S_DECIDE,
    S_WR_TX,
    S_RD_RX,
    S_GAP
  } state_t;

  state_t        r_state;
  logic          r_cyc;
  logic          r_we;
  logic [AW-1:0] r_adr;
  logic [31:0]   r_dat;
  logic          r_a_ready;
  logic          r_b_ready;
  logic          r_last_b;
  logic [7:0]    r_hold;
  logic [7:0]    r_gap;
  logic          r_init_done;

  logic          w_bus;
  logic          w_we;
  logic [AW-1:0] w_adr;
  logic [31:0]   w_dat;
  logic          w_done;
  logic          w_rx_go;
  logic          w_tx_go;
  logic          w_pick_a;
  logic          w_unused;

`ifdef CF_UART_SEQ_RX_EN
  logic       r_rx_go;
  logic       r_rx_valid;
  logic [7:0] r_rx_data;

  assign w_rx_go  = wbm_dat_i[RX_AVAIL_BIT] & ~r_rx_valid;
  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;
  assign w_unused = ^{wbm_dat_i};
`else
  assign w_rx_go  = 1'b0;
  assign rx_valid = 1'b0;
  assign rx_data  = 8'h00;
  assign w_unused = ^{wbm_dat_i, rx_ready};
`endif

  // Tie-break: the requester not granted last wins; pointer resets to B.
  assign w_tx_go  = wbm_dat_i[TX_READY_BIT] & (a_valid | b_valid) & ~w_rx_go;
  assign w_pick_a = a_valid & (~b_valid | r_last_b);
  assign w_done   = r_cyc & wbm_ack_i;

  always_comb begin
    w_bus = 1'b1;
    w_we  = 1'b0;
    w_adr = '0;
    w_dat = '0;
    unique case (r_state)
      S_INIT_PR: begin
        w_we  = 1'b1;
        w_adr = ADR_PR;
        w_dat = {16'h0000, PR_INIT};
      end
      S_INIT_CFG: begin
        w_we  = 1'b1;
        w_adr = ADR_CFG;
        w_dat = CFG_INIT;
      end
      S_INIT_CTRL: begin
        w_we  = 1'b1;
        w_adr = ADR_CTRL;
        w_dat = CTRL_INIT;
      end
      S_POLL: w_adr = ADR_RIS;
      S_WR_TX: begin
        w_we  = 1'b1;
        w_adr = ADR_TX;
        w_dat = {24'h0, r_hold};
      end
      S_RD_RX: w_adr = ADR_RX;
      default: w_bus = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_INIT_PR;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_a_ready   <= 1'b0;
      r_b_ready   <= 1'b0;
      r_last_b    <= 1'b1;
      r_hold      <= '0;
      r_gap       <= '0;
      r_init_done <= 1'b0;
`ifdef CF_UART_SEQ_RX_EN
      r_rx_go     <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_rx_data   <= '0;
`endif
    end else begin
      // A bus state starts its cycle one edge after entry, which
      // guarantees an idle bus cycle after every ack.
      if (!r_cyc && w_bus) begin
        r_cyc <= 1'b1;
        r_we  <= w_we;
        r_adr <= w_adr;
        r_dat <= w_dat;
      end
      if (w_done) begin
        r_cyc <= 1'b0;
        r_we  <= 1'b0;
        r_adr <= '0;
        r_dat <= '0;
      end
`ifdef CF_UART_SEQ_RX_EN
      if (r_rx_valid && rx_ready)
        r_rx_valid <= 1'b0;
`endif
      case (r_state)
        S_INIT_PR:
          if (w_done) r_state <= S_INIT_CFG;
        S_INIT_CFG:
          if (w_done) r_state <= S_INIT_CTRL;
        S_INIT_CTRL:
          if (w_done) begin
            r_init_done <= 1'b1;
            r_state     <= S_POLL;
          end
        S_POLL:
          // Decision is made on the RIS ack edge so the ready
          // pulse is a register that is high for the DECIDE cycle.
          if (w_done) begin
            r_a_ready <= w_tx_go & w_pick_a;
            r_b_ready <= w_tx_go & ~w_pick_a;
`ifdef CF_UART_SEQ_RX_EN
            r_rx_go   <= w_rx_go;
`endif
            r_state   <= S_DECIDE;
          end
        S_DECIDE: begin
          r_a_ready <= 1'b0;
          r_b_ready <= 1'b0;
`ifdef CF_UART_SEQ_RX_EN
          if (r_rx_go) r_state <= S_RD_RX;
          else
`endif
          if (r_a_ready && a_valid) begin
            r_hold   <= a_data;
            r_last_b <= 1'b0;
            r_state  <= S_WR_TX;
          end else if (r_b_ready && b_valid) begin
            r_hold   <= b_data;
            r_last_b <= 1'b1;
            r_state  <= S_WR_TX;
          end else begin
            r_gap    <= '0;
            r_state  <= S_GAP;
          end
        end
        S_WR_TX:
          if (w_done) r_state <= S_POLL;
`ifdef CF_UART_SEQ_RX_EN
        S_RD_RX:
          if (w_done) begin
            r_rx_data  <= wbm_dat_i[7:0];
            r_rx_valid <= 1'b1;
            r_state    <= S_POLL;
          end
`endif
        S_GAP:
          if (r_gap == 8'(POLL_GAP - 1)) begin
            r_gap   <= '0;
            r_state <= S_POLL;
          end else begin
            r_gap   <= r_gap + 8'd1;
          end
        default: r_state <= S_INIT_PR;
      endcase
    end
  end

  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
  assign wbm_we_o  = r_we;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_cyc;
  assign wbm_sel_o = {4{r_cyc}};
  assign a_ready   = r_a_ready;
  assign b_ready   = r_b_ready;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_cf_uart_wb_seq.sv
// tb_cf_uart_wb_seq: self-checking bench for cf_uart_wb_seq with a
// Wishbone slave model, table vectors, hand sequences and random traffic.
module tb_cf_uart_wb_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] adr;
  logic [31:0] dat_o, dat_i;
  logic [3:0] sel;
  logic cyc, stb, we, ack;
  logic [7:0] a_data = 8'h00, b_data = 8'h00;
  logic a_valid = 1'b0, b_valid = 1'b0;
  logic a_ready, b_ready;
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_ready = 1'b0;
  logic init_done;

  always #5 clk = ~clk;

  cf_uart_wb_seq dut (
    .clk_i(clk), .rst_i(rst),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i),
    .wbm_sel_o(sel), .wbm_cyc_o(cyc), .wbm_stb_o(stb),
    .wbm_we_o(we), .wbm_ack_i(ack),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .init_done(init_done)
  );

  // Slave model: ack after 'waits' extra cycles, registers by address.
  int waits = 0;
  logic [31:0] ris_val = 32'h0;
  logic [7:0] rx_byte = 8'hA5;
  int s_cnt;
  logic s_ack;
  assign ack = s_ack;
  assign dat_i = (adr == 16'h0F08) ? ris_val :
                 (adr == 16'h0000 && cyc) ? {24'h0, rx_byte} : 32'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ack <= 1'b0;
      s_cnt <= 0;
    end else if (s_ack) begin
      s_ack <= 1'b0;
      s_cnt <= 0;
    end else if (cyc) begin
      if (s_cnt >= waits) s_ack <= 1'b1;
      else s_cnt <= s_cnt + 1;
    end
  end

  typedef struct {
    bit we;
    logic [15:0] adr;
    logic [31:0] dat;
    bit idn;
  } txn_t;
  txn_t log_q[$];
  logic [7:0] got_tx[$];
  int viol = 0;
  logic done_prev = 1'b0;

  always @(posedge clk) begin
    int v;
    v = 0;
    if (!rst) begin
      if (cyc !== stb) v++;
      if (cyc && sel !== 4'hF) v++;
      if (!cyc && sel !== 4'h0) v++;
      if (done_prev && cyc) v++;
      if (cyc && s_ack) begin
        log_q.push_back('{we, adr, dat_o, init_done});
        if (we && adr == 16'h0004) begin
          got_tx.push_back(dat_o[7:0]);
          if (dat_o[31:8] != 24'h0) v++;
        end
      end
      done_prev <= cyc && s_ack;
    end else begin
      done_prev <= 1'b0;
    end
    viol <= viol + v;
  end

  int nn = 0;
  int fall_n = -1;
  logic cyc_q = 1'b0;
  int gap_q[$];
  logic ar_q = 1'b0, br_q = 1'b0;
  int viol2 = 0;

  always @(negedge clk) begin
    nn <= nn + 1;
    cyc_q <= cyc;
    if (cyc && !cyc_q && fall_n >= 0) gap_q.push_back(nn - fall_n);
    if (!cyc && cyc_q) fall_n <= nn;
    ar_q <= a_ready;
    br_q <= b_ready;
    if ((a_ready && ar_q) || (b_ready && br_q) || (a_ready && b_ready))
      viol2 <= viol2 + 1;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic wait_log(input int n, input int maxc);
    int c = 0;
    while (log_q.size() < n && c < maxc) begin
      @(posedge clk);
      c++;
    end
    #1;
    chk("log_wait", 64'(log_q.size() >= n), 1);
  endtask

  task automatic do_reset();
    int c = 0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    while (!init_done && c < 100) begin
      @(posedge clk);
      c++;
    end
    #1;
    chk("reinit_done", 64'(init_done), 1);
  endtask

  typedef struct {
    logic [31:0] ris;
    logic av;
    logic [7:0] ad;
    logic bv;
    logic [7:0] bd;
    int kind;
    logic [7:0] exp;
  } vec_t;
  vec_t vt[10];

  logic [7:0] qa[$], qb[$], exp_q[$];

  initial begin
    int n0, kind, c, ia, ib, ird, itx, nrd;
    bit lastb, takea, ha, hb, found;
    logic [7:0] tmp;

    // ris, A, B, expected grant (0 none, 1 A, 2 B), expected byte
    vt[0] = '{32'h1, 1, 8'hC3, 0, 8'h00, 1, 8'hC3};
    vt[1] = '{32'h1, 1, 8'h11, 1, 8'h22, 2, 8'h22};
    vt[2] = '{32'h1, 1, 8'h33, 1, 8'h44, 1, 8'h33};
    vt[3] = '{32'h0, 1, 8'h55, 0, 8'h00, 0, 8'h00};
    vt[4] = '{32'h1, 0, 8'h00, 0, 8'h00, 0, 8'h00};
    vt[5] = '{32'h1, 0, 8'h00, 1, 8'h5A, 2, 8'h5A};
    vt[6] = '{32'h1, 1, 8'h66, 1, 8'h77, 1, 8'h66};
    vt[7] = '{32'h6, 1, 8'h12, 0, 8'h00, 0, 8'h00};
    vt[8] = '{32'h10, 0, 8'h00, 1, 8'h34, 0, 8'h00};
    vt[9] = '{32'h1, 1, 8'h80, 1, 8'h81, 2, 8'h81};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus", 64'({cyc, stb, we, sel, adr, dat_o}), 0);
    chk("rst_stream", 64'({a_ready, b_ready, rx_valid, rx_data, init_done}), 0);

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("first_cyc", 64'({cyc, stb, we, adr}), 64'({3'b111, 16'h0008}));

    wait_log(3, 50);
    chk("init_pr", {log_q[0].we, log_q[0].adr, log_q[0].dat, log_q[0].idn},
        {1'b1, 16'h0008, 32'd10, 1'b0});
    chk("init_cfg", {log_q[1].we, log_q[1].adr, log_q[1].dat, log_q[1].idn},
        {1'b1, 16'h0010, 32'h3F08, 1'b0});
    chk("init_ctrl", {log_q[2].we, log_q[2].adr, log_q[2].dat, log_q[2].idn},
        {1'b1, 16'h000C, 32'h7, 1'b0});
    chk("init_done", 64'(init_done), 1);

    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n0 = got_tx.size();
      ris_val = vt[i].ris;
      a_valid = vt[i].av;
      a_data = vt[i].ad;
      b_valid = vt[i].bv;
      b_data = vt[i].bd;
      kind = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (a_ready) kind = 1;
        else if (b_ready) kind = 2;
        if (kind != 0) break;
      end
      @(posedge clk);
      #1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      chk($sformatf("vec%0d_grant", i), 64'(kind), 64'(vt[i].kind));
      if (vt[i].kind != 0) begin
        c = 0;
        while (got_tx.size() <= n0 && c < 40) begin
          @(posedge clk);
          c++;
        end
        #1;
        chk($sformatf("vec%0d_txdata", i), 64'(got_tx[n0]), 64'(vt[i].exp));
      end
    end

    // Both requesters held valid: grants must alternate.
    @(posedge clk);
    #1;
    n0 = got_tx.size();
    ris_val = 32'h1;
    a_data = 8'h11;
    b_data = 8'h22;
    a_valid = 1'b1;
    b_valid = 1'b1;
    c = 0;
    while (got_tx.size() < n0 + 4 && c < 200) begin
      @(posedge clk);
      c++;
    end
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    // pointer is B after vec9, so A leads
    chk("alt0", 64'(got_tx[n0]), 8'h11);
    chk("alt1", 64'(got_tx[n0 + 1]), 8'h22);
    chk("alt2", 64'(got_tx[n0 + 2]), 8'h11);
    chk("alt3", 64'(got_tx[n0 + 3]), 8'h22);

    // Idle polling spacing.
    ris_val = 32'h0;
    repeat (30) @(posedge clk);
    gap_q.delete();
    repeat (80) @(posedge clk);
    #1;
    chk("gap_count", 64'(gap_q.size() >= 3), 1);
    for (int i = 0; i < 3; i++)
      chk($sformatf("gap%0d", i), 64'(gap_q[i] >= 8 && gap_q[i] <= 20), 1);

    // RX path (or its absence) with A also pending.
    n0 = got_tx.size();
    ird = log_q.size();
    ris_val = 32'h9;
    rx_byte = 8'hA5;
    a_data = 8'h3C;
    a_valid = 1'b1;
    c = 0;
    while (got_tx.size() <= n0 && c < 100) begin
      @(posedge clk);
      c++;
    end
    #1;
    a_valid = 1'b0;
    chk("rxp_tx", 64'(got_tx[n0]), 8'h3C);
    itx = -1;
    nrd = 0;
    found = 0;
    for (int i = ird; i < log_q.size(); i++) begin
      if (!log_q[i].we && log_q[i].adr == 16'h0000 && !found) begin
        found = 1;
        nrd = i;
      end
      if (log_q[i].we && log_q[i].adr == 16'h0004 && itx < 0) itx = i;
    end
`ifdef CF_UART_SEQ_RX_EN
    chk("rx_before_tx", 64'(found && nrd < itx), 1);
    chk("rx_data", 64'({rx_valid, rx_data}), 64'({1'b1, 8'hA5}));
    repeat (60) @(posedge clk);
    #1;
    nrd = 0;
    for (int i = ird; i < log_q.size(); i++)
      if (!log_q[i].we && log_q[i].adr == 16'h0000) nrd++;
    chk("rx_single_read", 64'(nrd), 1);
    chk("rx_hold", 64'({rx_valid, rx_data}), 64'({1'b1, 8'hA5}));
    ris_val = 32'h0;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    chk("rx_clear", 64'(rx_valid), 0);
`else
    chk("norx_no_read", 64'(found), 0);
    rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rx_ready = 1'b0;
    ris_val = 32'h0;
    chk("norx_rx_valid", 64'({rx_valid, rx_data}), 0);
`endif

    // Random traffic against an ordering model.
    do_reset();
    repeat ($urandom_range(1, 12)) qa.push_back(8'($urandom));
    repeat ($urandom_range(1, 12)) qb.push_back(8'($urandom));
    lastb = 1'b1;
    ia = 0;
    ib = 0;
    exp_q.delete();
    while (ia < qa.size() || ib < qb.size()) begin
      if (ia < qa.size() && ib < qb.size()) takea = lastb;
      else takea = (ia < qa.size());
      if (takea) begin
        exp_q.push_back(qa[ia]);
        ia++;
        lastb = 1'b0;
      end else begin
        exp_q.push_back(qb[ib]);
        ib++;
        lastb = 1'b1;
      end
    end
    n0 = got_tx.size();
    a_valid = 1'b1;
    a_data = qa[0];
    b_valid = 1'b1;
    b_data = qb[0];
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      ha = a_valid && a_ready;
      hb = b_valid && b_ready;
      @(posedge clk);
      #1;
      if (ha) tmp = qa.pop_front();
      if (hb) tmp = qb.pop_front();
      a_valid = (qa.size() > 0);
      a_data = a_valid ? qa[0] : 8'h00;
      b_valid = (qb.size() > 0);
      b_data = b_valid ? qb[0] : 8'h00;
      if (!cyc) begin
        ris_val = {31'h0, 1'($urandom_range(0, 1))};
        waits = $urandom_range(0, 2);
      end
      if (qa.size() == 0 && qb.size() == 0 &&
          got_tx.size() >= n0 + exp_q.size()) break;
    end
    waits = 0;
    ris_val = 32'h0;
    chk("rand_count", 64'(got_tx.size() - n0), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("rand%0d", i), 64'(got_tx[n0 + i]), 64'(exp_q[i]));

    // Reset during a stretched TXDATA write.
    waits = 5;
    ris_val = 32'h1;
    a_data = 8'h99;
    a_valid = 1'b1;
    found = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (cyc && we && adr == 16'h0004) begin
        found = 1;
        break;
      end
    end
    chk("midtx_seen", 64'(found), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midtx_drop", 64'({cyc, stb}), 0);
    a_valid = 1'b0;
    log_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_log(1, 60);
    chk("restart_pr", {log_q[0].we, log_q[0].adr, log_q[0].dat},
        {1'b1, 16'h0008, 32'd10});

    repeat (5) @(posedge clk);
    chk("protocol", 64'(viol + viol2), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
